// File: rtl/rtc_display_pkg.sv
// rtc_display_pkg: shared types and constants for the RTC 7-segment display multiplexer
package rtc_display_pkg;
  typedef enum logic {BLANK, DRIVE} state_t;
  localparam int NUM_DIGITS = 6;
  localparam logic [7:0] ANODE_OFF = 8'hFF;
  localparam logic [7:0] SEG_OFF = 8'hFF;
  function automatic logic [7:0] anode_sel(input logic [2:0] idx);
    return ~(8'd1 << idx);
  endfunction
endpackage

// File: rtl/rtc_tick_counter.sv
// rtc_tick_counter: per-state cycle counter, flags the last cycle and restarts from zero
//   clk/rst_n : clock, asynchronous active-low reset
//   clr       : synchronous clear to zero
//   last      : terminal count (state length minus one)
//   done      : high during the final cycle of the current state
module rtc_tick_counter #(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic [W-1:0] last,
  output logic         done
);
  logic [W-1:0] cnt;
  assign done = cnt == last;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= (clr || done) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/rtc_display_mux.sv
// rtc_display_mux: time-multiplexes six active-low 7-segment patterns with blanking gaps
//   i_clk/i_rst_n        : clock, asynchronous active-low reset
//   i_enable             : scan enable, low blanks the display and restarts at digit 1
//   i_segout1..i_segout6 : active-low {dp,g,f,e,d,c,b,a} patterns, 1 = least-significant digit
//   o_anode              : active-low digit select, bit k drives digit k+1
//   o_segment            : active-low pattern for the selected digit
//   o_frame_tick         : one-cycle pulse after the last digit of each scan
module rtc_display_mux
  import rtc_display_pkg::*;
#(
  parameter int REFRESH_DIV  = 100_000,
  parameter int BLANK_CYCLES = 1_000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_enable,
  input  logic [7:0] i_segout1,
  input  logic [7:0] i_segout2,
  input  logic [7:0] i_segout3,
  input  logic [7:0] i_segout4,
  input  logic [7:0] i_segout5,
  input  logic [7:0] i_segout6,
  output logic [7:0] o_anode,
  output logic [7:0] o_segment,
  output logic       o_frame_tick
);
  localparam int MAX_CYC = REFRESH_DIV > BLANK_CYCLES ? REFRESH_DIV : BLANK_CYCLES;
  localparam int CW = $clog2(MAX_CYC);
  localparam logic [2:0] LAST_IDX = 3'(NUM_DIGITS - 1);
  state_t state, next_state;
  logic [2:0] idx, next_idx;
  logic [7:0] hold, next_hold;
  logic [7:0] segs [NUM_DIGITS];
  logic [CW-1:0] last;
  logic done, tick_d;
  logic [7:0] anode_d, seg_d;
  assign segs[0] = i_segout1;
  assign segs[1] = i_segout2;
  assign segs[2] = i_segout3;
  assign segs[3] = i_segout4;
  assign segs[4] = i_segout5;
  assign segs[5] = i_segout6;
  assign last = state == DRIVE ? CW'(REFRESH_DIV - 1) : CW'(BLANK_CYCLES - 1);
  rtc_tick_counter #(.W(CW)) u_cnt (
    .clk  (i_clk),
    .rst_n(i_rst_n),
    .clr  (!i_enable),
    .last (last),
    .done (done)
  );
  always_comb begin
    next_state = state;
    next_idx   = idx;
    next_hold  = hold;
    tick_d     = 1'b0;
    if (!i_enable) begin
      next_state = BLANK;
      next_idx   = '0;
    end else if (done && state == BLANK) begin
      next_state = DRIVE;
      next_hold  = segs[idx];
    end else if (done) begin
      next_state = BLANK;
      next_idx   = idx == LAST_IDX ? 3'd0 : idx + 3'd1;
      tick_d     = idx == LAST_IDX;
    end
    anode_d = next_state == DRIVE ? anode_sel(next_idx) : ANODE_OFF;
    seg_d   = next_state == DRIVE ? next_hold : SEG_OFF;
  end
  // Outputs are registered from the next-state decode so they line up with the state they describe.
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state        <= BLANK;
      idx          <= '0;
      hold         <= SEG_OFF;
      o_anode      <= ANODE_OFF;
      o_segment    <= SEG_OFF;
      o_frame_tick <= 1'b0;
    end else begin
      state        <= next_state;
      idx          <= next_idx;
      hold         <= next_hold;
      o_anode      <= anode_d;
      o_segment    <= seg_d;
      o_frame_tick <= tick_d;
    end
endmodule

// File: tb/tb_rtc_display_mux.sv
// tb_rtc_display_mux: randomized and directed checks against a time-based scan model
module tb_rtc_display_mux;
  localparam int RD = 4, BC = 2, P = RD + BC, FRAME = 6 * P;
  logic clk = 0, rst_n = 0, en = 0;
  logic [7:0] s [6];
  logic [7:0] o_anode, o_segment;
  logic o_frame_tick;
  int checks = 0, errors = 0;
  int t = 0;
  logic [7:0] cap = 8'hFF;
  always #5 clk = ~clk;
  rtc_display_mux #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(en),
    .i_segout1(s[0]), .i_segout2(s[1]), .i_segout3(s[2]),
    .i_segout4(s[3]), .i_segout5(s[4]), .i_segout6(s[5]),
    .o_anode(o_anode), .o_segment(o_segment), .o_frame_tick(o_frame_tick)
  );
  task automatic chk8(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s t=%0d got %h expected %h", tag, t, got, exp);
    end
  endtask
  task automatic chk1(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s t=%0d got %b expected %b", tag, t, got, exp);
    end
  endtask
  // Model: t counts enabled edges since the last restart; every digit slot is BC blank + RD driven cycles.
  task automatic check_outs();
    int ph, d;
    logic [7:0] ea, es;
    ph = t % P;
    d  = (t / P) % 6;
    ea = ph < BC ? 8'hFF : ~(8'd1 << d);
    es = ph < BC ? 8'hFF : cap;
    chk8("anode", o_anode, ea);
    chk8("segment", o_segment, es);
    chk1("frame_tick", o_frame_tick, t > 0 && t % FRAME == 0);
    chk1("one_hot_anode", $countones(~o_anode) <= 1, 1'b1);
    chk1("anode_top_bits", &o_anode[7:6], 1'b1);
  endtask
  task automatic cyc();
    if (!rst_n || !en) t = 0;
    else begin
      if (t % P == BC - 1) cap = s[(t / P) % 6];
      t++;
    end
    @(posedge clk);
    #1;
    check_outs();
  endtask
  initial begin
    for (int i = 0; i < 6; i++) s[i] = 8'($urandom);
    s[0] = 8'hC0;
    en = 1;
    repeat (2) cyc();
    rst_n = 1;
    repeat (2 * P) cyc();
    s[0] = 8'hC0; s[1] = 8'hF9; s[2] = 8'hA4; s[3] = 8'hB0; s[4] = 8'h99; s[5] = 8'h92;
    for (int k = 0; k < 200 && !((t / P) % 6 == 1 && t % P == BC + 1); k++) cyc();
    s[1] = 8'hA4;
    repeat (FRAME + P) cyc();
    repeat (2 * FRAME) cyc();
    for (int k = 0; k < 200 && !((t / P) % 6 == 3 && t % P == BC + 1); k++) cyc();
    en = 0;
    cyc();
    en = 1;
    repeat (2 * P) cyc();
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(9) == 0) s[$urandom_range(5)] = 8'($urandom);
      en = $urandom_range(49) != 0;
      cyc();
    end
    en = 1;
    for (int k = 0; k < 200 && !(t % P == BC + 1); k++) cyc();
    #2 rst_n = 0;
    #1;
    chk8("async_anode", o_anode, 8'hFF);
    chk8("async_segment", o_segment, 8'hFF);
    chk1("async_tick", o_frame_tick, 1'b0);
    repeat (2) cyc();
    rst_n = 1;
    repeat (FRAME + P) cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
